// File: rtl/dc_read_port_hyper.sv
// rtl/dc_read_port_hyper.sv - read-domain controller of the hyperbus dual-clock token FIFO
// Optional HYPER_DC_READ_LEVEL_EN adds a registered fill_level output.
module dc_read_port_hyper #(
    parameter int BUFFER_DEPTH = 8,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [BUFFER_DEPTH-1:0]            write_pointer,
    input  logic [BUFFER_DEPTH*DATA_WIDTH-1:0] buffer_data,
    output logic [BUFFER_DEPTH-1:0]            read_pointer,
    output logic [DATA_WIDTH-1:0]              data_out,
    output logic                               valid_out,
    input  logic                               ready_in
`ifdef HYPER_DC_READ_LEVEL_EN
    ,
    output logic [$clog2(BUFFER_DEPTH)-1:0]    fill_level
`endif
);

    logic [BUFFER_DEPTH-1:0] r_wp_meta;
    logic [BUFFER_DEPTH-1:0] r_wp_sync;
    logic [BUFFER_DEPTH-1:0] r_read_pointer;
    logic [DATA_WIDTH-1:0]   r_data_out;
    logic                    r_valid_out;

    logic                    w_empty;
    logic                    w_pop;
    logic [DATA_WIDTH-1:0]   w_slot;

    // Reset to bit 0 so an idle writer and reader agree the FIFO is empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wp_meta <= BUFFER_DEPTH'(1);
            r_wp_sync <= BUFFER_DEPTH'(1);
        end else begin
            r_wp_meta <= write_pointer;
            r_wp_sync <= r_wp_meta;
        end
    end

    // Two-hot transitional values read as empty, zero-hot as not empty; both safe.
    assign w_empty = |(r_read_pointer & r_wp_sync);
    assign w_pop   = !w_empty && (!r_valid_out || ready_in);

    always_comb begin
        w_slot = '0;
        for (int i = 0; i < BUFFER_DEPTH; i++) begin
            if (r_read_pointer[i]) begin
                w_slot = w_slot | buffer_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_read_pointer <= BUFFER_DEPTH'(1);
            r_data_out     <= '0;
            r_valid_out    <= 1'b0;
        end else if (w_pop) begin
            r_read_pointer <= {r_read_pointer[BUFFER_DEPTH-2:0], r_read_pointer[BUFFER_DEPTH-1]};
            r_data_out     <= w_slot;
            r_valid_out    <= 1'b1;
        end else if (r_valid_out && ready_in) begin
            r_valid_out    <= 1'b0;
        end
    end

    assign read_pointer = r_read_pointer;
    assign data_out     = r_data_out;
    assign valid_out    = r_valid_out;

`ifdef HYPER_DC_READ_LEVEL_EN
    localparam int LW = $clog2(BUFFER_DEPTH);

    logic [LW-1:0] r_fill_level;
    logic [LW-1:0] w_level;
    logic          w_found;
    int            w_rp_idx;

    // Distance in rotate-left steps from the read pointer to the nearest write-pointer bit.
    always_comb begin
        w_level  = '0;
        w_found  = 1'b0;
        w_rp_idx = 0;
        for (int i = 0; i < BUFFER_DEPTH; i++) begin
            if (r_read_pointer[i]) begin
                w_rp_idx = i;
            end
        end
        for (int k = BUFFER_DEPTH - 1; k >= 0; k--) begin
            if (r_wp_sync[(w_rp_idx + k) % BUFFER_DEPTH]) begin
                w_level = LW'(k);
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fill_level <= '0;
        end else if (w_found) begin
            r_fill_level <= w_level;
        end
    end

    assign fill_level = r_fill_level;
`endif

endmodule

// File: tb/tb_dc_read_port_hyper.sv
// tb/tb_dc_read_port_hyper.sv - self-checking bench for dc_read_port_hyper
module tb_dc_read_port_hyper;

    localparam int D = 8;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rstn;
    logic [D-1:0]     write_pointer;
    logic [D*W-1:0]   buffer_data;
    logic [D-1:0]     read_pointer;
    logic [W-1:0]     data_out;
    logic             valid_out;
    logic             ready_in;
`ifdef HYPER_DC_READ_LEVEL_EN
    logic [$clog2(D)-1:0] fill_level;
`endif

    always #5 clk = ~clk;

    dc_read_port_hyper #(.BUFFER_DEPTH(D), .DATA_WIDTH(W)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .write_pointer (write_pointer),
        .buffer_data   (buffer_data),
        .read_pointer  (read_pointer),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in)
`ifdef HYPER_DC_READ_LEVEL_EN
        ,
        .fill_level    (fill_level)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] mem [D];
    logic [W-1:0] exp_q [$];
    int           wr_idx;
    int           accepted;
    int           pushed;
    bit           mon_en;

    always_comb begin
        buffer_data = '0;
        for (int i = 0; i < D; i++) buffer_data[i*W +: W] = mem[i];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [D-1:0] onehot(input int idx);
        logic [D-1:0] v;
        v = '0;
        v[idx % D] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word();
        mem[wr_idx] = $urandom;
        exp_q.push_back(mem[wr_idx]);
        wr_idx = (wr_idx + 1) % D;
        write_pointer = onehot(wr_idx);
        pushed++;
    endtask

    task automatic do_reset();
        rstn          = 1'b0;
        write_pointer = onehot(0);
        ready_in      = 1'b0;
        wr_idx        = 0;
        pushed        = 0;
        accepted      = 0;
        exp_q.delete();
        step();
        step();
        rstn = 1'b1;
    endtask

    // Scoreboard: transfers are sampled on the falling edge, when the next rising edge's view is stable.
    initial begin
        logic         hold_v;
        logic [W-1:0] hold_d;
        hold_v = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            if (rstn && mon_en) begin
                check("rp_onehot", 64'($onehot(read_pointer)), 64'd1);
                if (hold_v) begin
                    check("hold_valid", 64'(valid_out), 64'd1);
                    check("hold_data", 64'(data_out), 64'(hold_d));
                end
                if (valid_out && ready_in) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 64'(data_out), 64'hDEAD_0000_0000);
                    end else begin
                        check("data_order", 64'(data_out), 64'(exp_q.pop_front()));
                    end
                    accepted++;
                end
                hold_v = valid_out && !ready_in;
                hold_d = data_out;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    typedef struct {
        logic [D-1:0] wp;
        logic         rdy;
        logic         ev;
        logic [D-1:0] erp;
        logic [W-1:0] ed;
        logic         chk_d;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int t;
        int s;
        bit seen;
        logic [W-1:0] v;

        for (int i = 0; i < D; i++) mem[i] = '0;
        mon_en = 1'b0;

        tbl[0] = '{8'h02, 1'b1, 1'b0, 8'h01, 32'h0, 1'b0};
        tbl[1] = '{8'h02, 1'b1, 1'b0, 8'h01, 32'h0, 1'b0};
        tbl[2] = '{8'h02, 1'b0, 1'b1, 8'h02, 32'hA5A5_0001, 1'b1};
        tbl[3] = '{8'h02, 1'b0, 1'b1, 8'h02, 32'hA5A5_0001, 1'b1};
        tbl[4] = '{8'h02, 1'b1, 1'b0, 8'h02, 32'hA5A5_0001, 1'b1};
        tbl[5] = '{8'h02, 1'b1, 1'b0, 8'h02, 32'hA5A5_0001, 1'b1};

        // Idle after reset
        do_reset();
        ready_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("reset_valid", 64'(valid_out), 64'd0);
            check("reset_rp", 64'(read_pointer), 64'h01);
        end

        // First word latency and handshake, table driven
        mem[0] = 32'hA5A5_0001;
        for (int i = 0; i < 6; i++) begin
            write_pointer = tbl[i].wp;
            ready_in      = tbl[i].rdy;
            step();
            check($sformatf("tbl%0d_valid", i), 64'(valid_out), 64'(tbl[i].ev));
            check($sformatf("tbl%0d_rp", i), 64'(read_pointer), 64'(tbl[i].erp));
            if (tbl[i].chk_d) check($sformatf("tbl%0d_data", i), 64'(data_out), 64'(tbl[i].ed));
        end
        wr_idx = 1;
        mon_en = 1'b1;

        // Seven words streamed through the wrap with no bubble
        ready_in = 1'b1;
        s = wr_idx;
        for (int i = 0; i < 7; i++) write_word();
        t = 0;
        while (!valid_out && t < 10) begin step(); t++; end
        check("stream_start", 64'(valid_out), 64'd1);
        for (int k = 0; k < 7; k++) begin
            check("stream_valid", 64'(valid_out), 64'd1);
            check("stream_rp", 64'(read_pointer), 64'(onehot(s + k + 1)));
            step();
        end
        check("stream_end_valid", 64'(valid_out), 64'd0);
        check("stream_wrap_rp", 64'(read_pointer), 64'h01);
        check("stream_count", 64'(exp_q.size()), 64'd0);

        // Backpressure with three words pending
        ready_in = 1'b0;
        s = wr_idx;
        for (int i = 0; i < 3; i++) write_word();
        t = 0;
        while (!valid_out && t < 10) begin step(); t++; end
        check("bp_valid", 64'(valid_out), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_rp", 64'(read_pointer), 64'(onehot(s + 1)));
        end
        ready_in = 1'b1;
        t = 0;
        while ((exp_q.size() != 0 || valid_out) && t < 10) begin step(); t++; end
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        check("bp_rp_end", 64'(read_pointer), 64'(onehot(s + 3)));

        // Transitional synchronized write pointers
        mon_en = 1'b0;
        do_reset();
        ready_in      = 1'b1;
        write_pointer = 8'h03;
        for (int i = 0; i < 6; i++) step();
        check("twohot_valid", 64'(valid_out), 64'd0);
        check("twohot_rp", 64'(read_pointer), 64'h01);
        mem[0]        = 32'h5A5A_C3C3;
        ready_in      = 1'b0;
        write_pointer = 8'h00;
        t = 0;
        while (!valid_out && t < 10) begin step(); t++; end
        check("zerohot_valid", 64'(valid_out), 64'd1);
        check("zerohot_data", 64'(data_out), 64'h5A5A_C3C3);
        check("zerohot_rp", 64'(read_pointer), 64'h02);

        // Randomized traffic against the queue model
        do_reset();
        mon_en = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            ready_in = ($urandom % 4) != 0;
            if ((pushed - accepted) < D - 1 && ($urandom % 2) == 1) write_word();
            step();
        end
        ready_in = 1'b1;
        t = 0;
        while ((exp_q.size() != 0 || valid_out) && t < 30) begin step(); t++; end
        check("rand_drained", 64'(exp_q.size()), 64'd0);
        check("rand_accepted", 64'(accepted), 64'(pushed));

        // Asynchronous reset in the middle of a stream
        for (int i = 0; i < 4; i++) write_word();
        ready_in = 1'b0;
        t = 0;
        while (!valid_out && t < 10) begin step(); t++; end
        check("pre_areset_valid", 64'(valid_out), 64'd1);
        #2;
        rstn = 1'b0;
        exp_q.delete();
        #1;
        check("areset_valid", 64'(valid_out), 64'd0);
        check("areset_rp", 64'(read_pointer), 64'h01);
        check("areset_data", 64'(data_out), 64'd0);
        do_reset();

`ifdef HYPER_DC_READ_LEVEL_EN
        check("level_reset", 64'(fill_level), 64'd0);
        ready_in = 1'b0;
        for (int i = 0; i < 5; i++) write_word();
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (fill_level == 3'd5) seen = 1'b1;
        end
        check("level_five", 64'(seen), 64'd1);
        ready_in = 1'b1;
        t = 0;
        while ((exp_q.size() != 0 || valid_out) && t < 20) begin step(); t++; end
        check("level_drained", 64'(fill_level), 64'd0);
`endif

        v = '0;
        if (v != '0) $display("unreachable");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dc_read_port_hyper.md
# dc_read_port_hyper

Read-side (destination clock domain) controller of the hyperbus dual-clock token FIFO. It owns the one-hot read pointer and synchronizes the writer's one-hot write pointer into its own clock. It detects empty, selects the slot at the read pointer from the shared buffer array, and presents it through a registered valid/ready output stage. It is the counterpart of the write-side full detection: it publishes the read pointer that the write side compares against.

## Interface
- BUFFER_DEPTH, 8: number of FIFO slots = one-hot pointer width; legal range 4..32.
- DATA_WIDTH, 32: width of one slot.
- clk  input  1  read-domain clock; the block's only clock.
- rstn  input  1  asynchronous, active-low reset.
- write_pointer  input  BUFFER_DEPTH  one-hot write pointer from the write domain; asynchronous to clk.
- buffer_data  input  BUFFER_DEPTH*DATA_WIDTH  flattened slot array; slot i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- read_pointer  output  BUFFER_DEPTH  one-hot read pointer, registered; sent to the write domain.
- data_out  output  DATA_WIDTH  head-of-FIFO data, registered.
- valid_out  output  1  data_out holds a valid word.
- ready_in  input  1  consumer accepts data_out this cycle.

## Operation
- write_pointer passes through a 2-flop synchronizer, wp_sync. Its reset value is 'b1, so it matches the writer's reset position.
- empty = |(read_pointer & wp_sync), combinational from registered values.
  - A transitional wp_sync with two bits set reads as empty when read_pointer is on the old bit. This is conservative and safe.
  - A transitional wp_sync with zero bits set reads as not empty. This is safe because the writer advances only after the slot is written.
- Output stage: one register (data_out, valid_out).
  - pop = !empty & (!valid_out | ready_in).
  - On pop: data_out <= slot at read_pointer, valid_out <= 1, and read_pointer rotates left by one (MSB wraps to bit 0).
  - Without pop, when valid_out & ready_in: valid_out <= 0.
  - Otherwise everything holds.
- Handshake: a transfer occurs on a clock edge with valid_out & ready_in.
  - data_out and valid_out must not change while valid_out=1 and ready_in=0.
  - valid_out never depends combinationally on ready_in.
- Back-to-back: when valid_out=1, ready_in=1 and !empty, a new word loads on the same edge, giving 1 word/cycle sustained.
- read_pointer is always exactly one-hot; it is never driven with zero or multiple bits set.

## Timing
- Reset values: read_pointer='b1, wp_sync stages='b1, valid_out=0, data_out=0.
- Write-pointer advance to valid_out high: 2 cycles of synchronization plus 1 register, i.e. 3 clk edges after the first edge sampling the new value.
- read_pointer advances on the pop edge. The write side sees it after its own synchronizer; full-side margin covers this.
- Empty boundary: the last word pops, read_pointer then equals wp_sync, and no further pop occurs. valid_out falls on the edge where that word is consumed.
- Wrap-around: read_pointer moves from bit BUFFER_DEPTH-1 to bit 0 with no bubble.
- Simultaneous write advance and pop: the pop uses the current wp_sync. The new word becomes eligible once wp_sync updates.
- Reset mid-operation: asynchronous clear to reset values. Any in-flight data_out is discarded. The write domain must be reset in the same event.

## Configuration
- HYPER_DC_READ_LEVEL_EN
- Defined:
  - adds output port fill_level [$clog2(BUFFER_DEPTH)-1:0], registered, reset 0.
  - fill_level = number of rotate-left steps from read_pointer to the first set bit of wp_sync. It is 0 when empty.
  - It updates every cycle and holds its previous value when wp_sync is all-zero.
  - It does not count the word held in the output register.
- Undefined: the port and its logic are absent; everything else is identical.

## Test plan
- Reset, write_pointer='b1, ready_in=1 -> valid_out=0 and read_pointer=8'b00000001, held for 20 cycles.
- Write_pointer steps to 'b10 with slot0=32'hA5A5_0001 -> valid_out=1 with data_out=32'hA5A5_0001 3 edges later; read_pointer='b10 on the same edge; valid_out=0 one cycle after acceptance.
- Fill 7 slots, ready_in=1 continuously -> 7 consecutive accepted words in slot order; read_pointer wraps from 8'b10000000 to 8'b00000001 without a gap.
- ready_in=0 with 3 words pending -> data_out and valid_out are stable; read_pointer advances once only, to the slot after the held word; resuming ready_in drains the remaining 2 words.
- wp_sync forced transitional (two bits, e.g. 'b11 with read_pointer='b01) -> no pop; forced 'b00 with read_pointer='b01 -> pop of slot0.
- rstn pulsed low mid-stream, asynchronously between edges -> valid_out=0 and read_pointer='b1 immediately. With HYPER_DC_READ_LEVEL_EN, fill_level=0, and after writing 5 words fill_level=5 within 3 cycles.
